// File: rtl/xreg_bus_slave.sv
// APB3-style register slave: decodes each transfer into one-cycle sw_wr/sw_rd strobes and returns read data.
// Latency: pready on the 3rd access-phase cycle (two wait states); all outputs registered.
module xreg_bus_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int REG_CNT     = 8,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [ADDR_WIDTH-1:0]         paddr,
  input  logic [DATA_WIDTH-1:0]         pwdata,
  output logic                          pready,
  output logic [DATA_WIDTH-1:0]         prdata,
  output logic                          pslverr,
  output logic [REG_CNT-1:0]            sw_wr,
  output logic [REG_CNT-1:0]            sw_rd,
  output logic [DATA_WIDTH-1:0]         sw_wr_data,
  input  logic [REG_CNT*DATA_WIDTH-1:0] reg_rd_data
);

  localparam int SHIFT = $clog2(ADDR_STRIDE);
  localparam logic [ADDR_WIDTH-1:0] BASE_A      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_MASK = ADDR_WIDTH'(ADDR_STRIDE - 1);
  localparam logic [ADDR_WIDTH-1:0] REG_CNT_A   = ADDR_WIDTH'(REG_CNT);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RESP} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] slot;
  logic                  hit;
  logic [REG_CNT-1:0]    sel_vec;
  logic [DATA_WIDTH-1:0] rd_sel;
  logic                  latch_en;
  logic                  go_strobe;
  logic                  go_resp;

  // Address decode works on the latched setup-phase address only.
  always_comb begin
    offset = addr_q - BASE_A;
    slot   = offset >> SHIFT;
    hit    = (addr_q >= BASE_A) && ((offset & STRIDE_MASK) == '0) && (slot < REG_CNT_A);
  end

  always_comb begin
    sel_vec = '0;
    rd_sel  = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      sel_vec[i] = hit && (slot == ADDR_WIDTH'(i));
      if (sel_vec[i]) rd_sel = reg_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    go_strobe = 1'b0;
    go_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          state_nxt = SETUP;
          latch_en  = 1'b1;
        end
      end
      SETUP: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (penable) begin
          state_nxt = STROBE;
          go_strobe = 1'b1;
        end else begin
          latch_en  = 1'b1;
        end
      end
      STROBE: begin
        // The strobe has already been issued; a dropped psel only suppresses the response.
        if (psel) begin
          state_nxt = RESP;
          go_resp   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      sw_wr      <= '0;
      sw_rd      <= '0;
      sw_wr_data <= '0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      prdata     <= '0;
    end else begin
      if (latch_en) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
      end
      sw_wr   <= (go_strobe && write_q)  ? sel_vec : '0;
      sw_rd   <= (go_strobe && !write_q) ? sel_vec : '0;
      if (go_strobe && write_q) sw_wr_data <= wdata_q;
      pready  <= go_resp;
      pslverr <= go_resp && !hit;
      // Captured on the same edge a read-clear field clears, so the pre-update value is returned.
      if (state == STROBE) prdata <= (hit && !write_q) ? rd_sel : '0;
    end
  end

endmodule
